// File: rtl/alu_arbiter_if.sv
// Bundles the requester, ALU and result-drain signals of alu_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0;
    logic [2:0]       op0;
    logic [31:0]      a0;
    logic [31:0]      b0;
    logic             gnt0;
    logic             req1;
    logic [2:0]       op1;
    logic [31:0]      a1;
    logic [31:0]      b1;
    logic             gnt1;
    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             out_valid;
    logic             out_id;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_err;
    logic             out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        input  alu_result, alu_zero, out_ready,
        output gnt0, gnt1, alu_op, alu_a, alu_b,
        output out_valid, out_id, out_result, out_zero, out_err, cnt0, cnt1
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        output alu_result, alu_zero, out_ready,
        input  gnt0, gnt1, alu_op, alu_a, alu_b,
        input  out_valid, out_id, out_result, out_zero, out_err, cnt0, cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 32-bit ALU between two requesters, with a one-entry
// result register drained by valid/ready and a completion counter per requester.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            3'b001, 3'b010, 3'b101, 3'b111: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic             slot_free_s;
    logic             drain_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             grant_s;
    logic             sel_s;
    logic             sel_legal_s;
    logic [2:0]       sel_op_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;
    logic [2:0]       alu_op_s;

    logic             out_valid_q, out_valid_d;
    logic             out_id_q, out_id_d;
    logic [31:0]      out_result_q, out_result_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q, out_err_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    assign slot_free_s = !out_valid_q || bus.out_ready;
    assign drain_s     = out_valid_q && bus.out_ready;

    // Round-robin grant, only issued while the output slot can take a result
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (slot_free_s) begin
            if (bus.req0 && bus.req1) begin
                if (prio_q) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end else if (bus.req0) begin
                gnt0_s = 1'b1;
            end else if (bus.req1) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
        grant_s = gnt0_s || gnt1_s;
        // Without a grant the ALU still follows the requester next in line
        sel_s   = gnt1_s || (!gnt0_s && prio_q);
    end

    // Operand mux toward the shared ALU; illegal opcodes are parked on add
    always_comb begin
        if (sel_s) begin
            sel_op_s = bus.op1;
            sel_a_s  = bus.a1;
            sel_b_s  = bus.b1;
        end else begin
            sel_op_s = bus.op0;
            sel_a_s  = bus.a0;
            sel_b_s  = bus.b0;
        end
        sel_legal_s = op_legal(sel_op_s);
        if (sel_legal_s) begin
            alu_op_s = sel_op_s;
        end else begin
            alu_op_s = 3'b001;
        end
    end

    // Next state of the result slot, round-robin pointer and completion counters
    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_err_d    = out_err_q;
        prio_d       = prio_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant_s) begin
            out_valid_d = 1'b1;
            out_id_d    = gnt1_s;
            prio_d      = !gnt1_s;
            if (sel_legal_s) begin
                out_result_d = bus.alu_result;
                out_zero_d   = bus.alu_zero;
                out_err_d    = 1'b0;
            end else begin
                out_result_d = 32'd0;
                out_zero_d   = 1'b0;
                out_err_d    = 1'b1;
            end
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (drain_s) begin
            if (out_id_q) begin
                cnt1_d = cnt1_q + CNT_ONE;
            end else begin
                cnt0_d = cnt0_q + CNT_ONE;
            end
        end else begin
            cnt0_d = cnt0_q;
            cnt1_d = cnt1_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_result_q <= 32'd0;
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
            prio_q       <= 1'b0;
            cnt0_q       <= {CNT_W{1'b0}};
            cnt1_q       <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_err_q    <= out_err_d;
            prio_q       <= prio_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.gnt0       = gnt0_s;
    assign bus.gnt1       = gnt1_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.alu_a      = sel_a_s;
    assign bus.alu_b      = sel_b_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_result = out_result_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_err    = out_err_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;
    localparam int CW      = 2;
    localparam int CNT_MOD = 1 << CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(CW)) bus ();
    alu_arbiter #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nchk = 0;
    int nerr = 0;

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b101) || (op == 3'b111);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b001:  return x + y;
            3'b010:  return x | y;
            3'b101:  return x - y;
            3'b111:  return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU attached to the arbiter's ALU port
    always_comb begin
        bus.alu_result = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_zero   = (ref_alu(bus.alu_op, bus.alu_a, bus.alu_b) == 32'd0);
    end

    // Reference model state
    bit          m_valid, m_id, m_zero, m_err, m_prio;
    logic [31:0] m_result;
    int          m_cnt [2];

    logic        obs_gnt0, obs_gnt1, exp_gnt0, exp_gnt1;
    logic [2:0]  obs_op, exp_op;
    logic [31:0] obs_a, obs_b, exp_a, exp_b;
    logic [2:0]  legal_ops [4] = '{3'b001, 3'b010, 3'b101, 3'b111};

    task automatic model_reset();
        m_valid = 1'b0; m_id = 1'b0; m_zero = 1'b0; m_err = 1'b0; m_prio = 1'b0;
        m_result = 32'd0; m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic zero_inputs();
        bus.req0 = 1'b0; bus.op0 = 3'b000; bus.a0 = 32'd0; bus.b0 = 32'd0;
        bus.req1 = 1'b0; bus.op1 = 3'b000; bus.a1 = 32'd0; bus.b1 = 32'd0;
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        zero_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, sample combinational outputs, advance model at posedge
    task automatic drive_cycle(input bit r0, input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                               input bit r1, input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                               input bit rdy);
        int g;
        int s;
        logic [2:0]  op;
        logic [31:0] xa, yb;
        @(negedge clk);
        bus.req0 = r0; bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
        bus.req1 = r1; bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
        bus.out_ready = rdy;
        #2;
        obs_gnt0 = bus.gnt0; obs_gnt1 = bus.gnt1;
        obs_op = bus.alu_op; obs_a = bus.alu_a; obs_b = bus.alu_b;
        g = -1;
        if (!m_valid || rdy) begin
            if (r0 && r1)  g = int'(m_prio);
            else if (r0)   g = 0;
            else if (r1)   g = 1;
        end
        s  = (g >= 0) ? g : int'(m_prio);
        op = (s == 1) ? o1 : o0;
        xa = (s == 1) ? x1 : x0;
        yb = (s == 1) ? y1 : y0;
        exp_gnt0 = (g == 0);
        exp_gnt1 = (g == 1);
        exp_op   = is_legal(op) ? op : 3'b001;
        exp_a    = xa;
        exp_b    = yb;
        @(posedge clk);
        if (m_valid && rdy) m_cnt[m_id] = (m_cnt[m_id] + 1) % CNT_MOD;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_id    = (g == 1);
            m_prio  = (g == 0);
            if (is_legal(op)) begin
                m_result = ref_alu(op, xa, yb);
                m_zero   = (m_result == 32'd0);
                m_err    = 1'b0;
            end else begin
                m_result = 32'd0;
                m_zero   = 1'b0;
                m_err    = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic drive_idle(input bit rdy);
        drive_cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0, rdy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        zero_inputs();
        model_reset();
        @(negedge clk);
        #1;
        nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        nchk++; if (bus.out_id !== 1'b0) begin nerr++; $display("FAIL reset_id: got %0b want 0", bus.out_id); end
        nchk++; if (bus.out_result !== 32'd0) begin nerr++; $display("FAIL reset_result: got %0h want 0", bus.out_result); end
        nchk++; if ({bus.out_zero, bus.out_err} !== 2'b00) begin nerr++; $display("FAIL reset_flags: got %b want 00", {bus.out_zero, bus.out_err}); end
        nchk++; if ({bus.cnt0, bus.cnt1} !== {CW{2'b00}}) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        drive_cycle(1'b1, 3'b001, 32'd5, 32'd7, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        nchk++; if ({obs_gnt0, obs_gnt1} !== 2'b10) begin nerr++; $display("FAIL single_gnt: got %b want 10", {obs_gnt0, obs_gnt1}); end
        nchk++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL single_valid: got %0b want 1", bus.out_valid); end
        nchk++; if (bus.out_id !== 1'b0) begin nerr++; $display("FAIL single_id: got %0b want 0", bus.out_id); end
        nchk++; if (bus.out_result !== 32'd12) begin nerr++; $display("FAIL single_result: got %0d want 12", bus.out_result); end
        nchk++; if (bus.out_zero !== 1'b0) begin nerr++; $display("FAIL single_zero: got %0b want 0", bus.out_zero); end
        drive_idle(1'b1);
        nchk++; if (bus.cnt0 !== CW'(1)) begin nerr++; $display("FAIL single_cnt0: got %0d want 1", bus.cnt0); end
        nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL single_drain: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, legal_ops[$urandom_range(0, 3)], $urandom, $urandom,
                        1'b1, legal_ops[$urandom_range(0, 3)], $urandom, $urandom, 1'b1);
            nchk++; if ({obs_gnt0, obs_gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL contention_gnt%0d: got %b", i, {obs_gnt0, obs_gnt1}); end
            nchk++; if (bus.out_id !== 1'((i % 2))) begin nerr++; $display("FAIL contention_id%0d: got %0b want %0d", i, bus.out_id, i % 2); end
            nchk++; if (bus.out_result !== m_result) begin nerr++; $display("FAIL contention_result%0d: got %0h want %0h", i, bus.out_result, m_result); end
        end
        drive_idle(1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] x, y;
        apply_reset();
        drive_cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 3'b101, 32'd9, 32'd9, 1'b0);
        nchk++; if (obs_gnt1 !== 1'b1) begin nerr++; $display("FAIL bp_first_gnt: got %0b want 1", obs_gnt1); end
        x = $urandom; y = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 3'b001, x, y, 1'b1, 3'b010, 32'd1, 32'd2, 1'b0);
            nchk++; if ({obs_gnt0, obs_gnt1} !== 2'b00) begin nerr++; $display("FAIL bp_hold_gnt%0d: got %b want 00", i, {obs_gnt0, obs_gnt1}); end
            nchk++; if ({bus.out_valid, bus.out_id, bus.out_zero} !== 3'b111) begin nerr++; $display("FAIL bp_hold_flags%0d: got %b want 111", i, {bus.out_valid, bus.out_id, bus.out_zero}); end
            nchk++; if (bus.out_result !== 32'd0) begin nerr++; $display("FAIL bp_hold_result%0d: got %0h want 0", i, bus.out_result); end
        end
        drive_cycle(1'b1, 3'b001, x, y, 1'b1, 3'b010, 32'd1, 32'd2, 1'b1);
        nchk++; if (obs_gnt0 !== 1'b1) begin nerr++; $display("FAIL bp_release_gnt: got %0b want 1", obs_gnt0); end
        nchk++; if ({bus.out_valid, bus.out_id} !== 2'b10) begin nerr++; $display("FAIL bp_release_slot: got %b want 10", {bus.out_valid, bus.out_id}); end
        nchk++; if (bus.out_result !== x + y) begin nerr++; $display("FAIL bp_release_result: got %0h want %0h", bus.out_result, x + y); end
        nchk++; if (bus.cnt1 !== CW'(1)) begin nerr++; $display("FAIL bp_release_cnt1: got %0d want 1", bus.cnt1); end
        drive_idle(1'b1);
    endtask

    task automatic test_illegal();
        int c0;
        c0 = m_cnt[0];
        drive_cycle(1'b1, 3'b011, 32'd3, 32'd4, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        nchk++; if (obs_op !== 3'b001) begin nerr++; $display("FAIL illegal_alu_op: got %b want 001", obs_op); end
        nchk++; if ({bus.out_valid, bus.out_err, bus.out_zero} !== 3'b110) begin nerr++; $display("FAIL illegal_flags: got %b want 110", {bus.out_valid, bus.out_err, bus.out_zero}); end
        nchk++; if (bus.out_result !== 32'd0) begin nerr++; $display("FAIL illegal_result: got %0h want 0", bus.out_result); end
        drive_cycle(1'b1, 3'b111, 32'd3, 32'd4, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        nchk++; if ({bus.out_result, bus.out_err} !== {32'd1, 1'b0}) begin nerr++; $display("FAIL slt_result: got %0h/%0b want 1/0", bus.out_result, bus.out_err); end
        nchk++; if (bus.cnt0 !== CW'((c0 + 1) % CNT_MOD)) begin nerr++; $display("FAIL illegal_cnt0: got %0d want %0d", bus.cnt0, (c0 + 1) % CNT_MOD); end
        drive_idle(1'b1);
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 3'b001, $urandom, $urandom, 1'b1);
        drive_idle(1'b1);
        nchk++; if (bus.cnt1 !== CW'(1)) begin nerr++; $display("FAIL wrap_cnt1: got %0d want 1", bus.cnt1); end
        nchk++; if (bus.cnt0 !== CW'(0)) begin nerr++; $display("FAIL wrap_cnt0: got %0d want 0", bus.cnt0); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 3'b010, 32'h1234, 32'h0001, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        nchk++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL midrst_pre_valid: got %0b want 1", bus.out_valid); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        zero_inputs();
        model_reset();
        #1;
        nchk++; if ({bus.out_valid, bus.out_id, bus.out_zero, bus.out_err} !== 4'b0000) begin nerr++; $display("FAIL midrst_flags: got %b want 0000", {bus.out_valid, bus.out_id, bus.out_zero, bus.out_err}); end
        nchk++; if (bus.out_result !== 32'd0) begin nerr++; $display("FAIL midrst_result: got %0h want 0", bus.out_result); end
        nchk++; if ({bus.cnt0, bus.cnt1} !== {CW{2'b00}}) begin nerr++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 3'b001, 32'd1, 32'd1, 1'b1, 3'b001, 32'd2, 32'd2, 1'b1);
        nchk++; if ({obs_gnt0, obs_gnt1} !== 2'b10) begin nerr++; $display("FAIL midrst_post_gnt: got %b want 10", {obs_gnt0, obs_gnt1}); end
        drive_idle(1'b1);
    endtask

    task automatic test_random();
        logic [31:0] x0, y0, x1, y1;
        for (int i = 0; i < 300; i++) begin
            x0 = $urandom; x1 = $urandom;
            y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
            y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            drive_cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), x0, y0,
                        $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), x1, y1,
                        $urandom_range(0, 9) < 7);
            nchk++; if ({obs_gnt0, obs_gnt1} !== {exp_gnt0, exp_gnt1}) begin nerr++; $display("FAIL rand_gnt@%0d: got %b want %b", i, {obs_gnt0, obs_gnt1}, {exp_gnt0, exp_gnt1}); end
            nchk++; if ({obs_op, obs_a, obs_b} !== {exp_op, exp_a, exp_b}) begin nerr++; $display("FAIL rand_alu_drive@%0d: got %b/%h/%h want %b/%h/%h", i, obs_op, obs_a, obs_b, exp_op, exp_a, exp_b); end
            nchk++; if ({bus.out_valid, bus.out_id, bus.out_zero, bus.out_err} !== {m_valid, m_id, m_zero, m_err}) begin nerr++; $display("FAIL rand_flags@%0d: got %b want %b", i, {bus.out_valid, bus.out_id, bus.out_zero, bus.out_err}, {m_valid, m_id, m_zero, m_err}); end
            nchk++; if (bus.out_result !== m_result) begin nerr++; $display("FAIL rand_result@%0d: got %h want %h", i, bus.out_result, m_result); end
            nchk++; if ({bus.cnt0, bus.cnt1} !== {CW'(m_cnt[0]), CW'(m_cnt[1])}) begin nerr++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", i, bus.cnt0, bus.cnt1, m_cnt[0], m_cnt[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
